multicycle_control: RTL and testbench

Multi-cycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction instead of decoding combinationally in one cycle. Sits between the instruction register and the datapath muxes, ALU, register file and memories. Adds variable-latency memory handshakes, MOVZ/signop decode, illegal-opcode trap and memory timeout.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit boundary: instruction/flag/handshake inputs in, datapath controls,
// strobes and trap flags out. The control unit uses "master", the datapath "slave".
interface multicycle_control_if #(
    parameter int ALUOP_W = 4
);
    logic [10:0]        opcode;
    logic               zero;
    logic               imem_ready;
    logic               dmem_ready;

    logic               imem_req;
    logic               ir_write;
    logic               pc_write;
    logic               pc_src;
    logic               reg2loc;
    logic               alusrc;
    logic               mem2reg;
    logic               uncond_branch;
    logic               branch;
    logic [ALUOP_W-1:0] aluop;
    logic [2:0]         signop;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               illegal;
    logic               timeout;
    logic               instr_done;
    logic [2:0]         state;

    modport master (
        input  opcode, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
               uncond_branch, branch, aluop, signop, memread, memwrite, regwrite,
               illegal, timeout, instr_done, state
    );

    modport slave (
        output opcode, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
               uncond_branch, branch, aluop, signop, memread, memwrite, regwrite,
               illegal, timeout, instr_done, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with variable-latency
// memory handshakes, illegal-opcode trap and handshake timeout into a sticky HALT.
module multicycle_control #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter bit EN_MOVZ     = 1'b1
) (
    input logic                  CLK,
    input logic                  Reset_L,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        K_NONE, K_LOAD, K_STORE, K_ALU, K_CBZ, K_B
    } kind_e;

    localparam int               CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e             state_q;
    kind_e              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               reg2loc_q, reg2loc_d;
    logic               alusrc_q, alusrc_d;
    logic               mem2reg_q, mem2reg_d;
    logic               branch_q, branch_d;
    logic               uncond_q, uncond_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic [2:0]         signop_q, signop_d;
    logic               memread_q, memwrite_q;
    logic               illegal_q, timeout_q;

    // Opcode decode; case items are tried in order, so the first match wins.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        kind_d    = K_NONE;
        reg2loc_d = 1'b0;
        alusrc_d  = 1'b0;
        mem2reg_d = 1'b0;
        branch_d  = 1'b0;
        uncond_d  = 1'b0;
        aluop_d   = '0;
        signop_d  = 3'b000;
        casez (bus.opcode)
            11'b??111000010: begin
                kind_d = K_LOAD;  alusrc_d = 1'b1; mem2reg_d = 1'b1;
                aluop_d = ALUOP_W'(4'b0010); signop_d = 3'b001;
            end
            11'b??111000000: begin
                kind_d = K_STORE; reg2loc_d = 1'b1; alusrc_d = 1'b1;
                aluop_d = ALUOP_W'(4'b0010); signop_d = 3'b001;
            end
            11'b110100101??: begin
                if (EN_MOVZ) begin
                    kind_d = K_ALU; alusrc_d = 1'b1;
                    aluop_d = ALUOP_W'(4'b1000); signop_d = 3'b100;
                end
            end
            11'b?0?01011???: begin kind_d = K_ALU; aluop_d = ALUOP_W'(4'b0010); end
            11'b?0?10001???: begin kind_d = K_ALU; alusrc_d = 1'b1; aluop_d = ALUOP_W'(4'b0010); end
            11'b?1?01011???: begin kind_d = K_ALU; aluop_d = ALUOP_W'(4'b0110); end
            11'b?1?10001???: begin kind_d = K_ALU; alusrc_d = 1'b1; aluop_d = ALUOP_W'(4'b0110); end
            11'b?0001010???: begin kind_d = K_ALU; aluop_d = ALUOP_W'(4'b0000); end
            11'b?0101010???: begin kind_d = K_ALU; aluop_d = ALUOP_W'(4'b0001); end
            11'b?011010????: begin
                kind_d = K_CBZ; reg2loc_d = 1'b1; branch_d = 1'b1;
                aluop_d = ALUOP_W'(4'b0111); signop_d = 3'b011;
            end
            11'b?00101?????: begin kind_d = K_B; uncond_d = 1'b1; signop_d = 3'b010; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q    <= S_FETCH;
            kind_q     <= K_NONE;
            cnt_q      <= '0;
            reg2loc_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            mem2reg_q  <= 1'b0;
            branch_q   <= 1'b0;
            uncond_q   <= 1'b0;
            aluop_q    <= '0;
            signop_q   <= 3'b000;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking default, overridden below only while a handshake waits.
            cnt_q <= '0;
            unique case (state_q)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        state_q <= S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    kind_q    <= kind_d;
                    reg2loc_q <= reg2loc_d;
                    alusrc_q  <= alusrc_d;
                    mem2reg_q <= mem2reg_d;
                    branch_q  <= branch_d;
                    uncond_q  <= uncond_d;
                    aluop_q   <= aluop_d;
                    signop_q  <= signop_d;
                    if (kind_d == K_NONE) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_HALT;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (kind_q == K_CBZ || kind_q == K_B) begin
                        state_q <= S_FETCH;
                    end else if (kind_q == K_LOAD) begin
                        memread_q <= 1'b1;
                        state_q   <= S_MEM;
                    end else if (kind_q == K_STORE) begin
                        memwrite_q <= 1'b1;
                        state_q    <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        memread_q  <= 1'b0;
                        memwrite_q <= 1'b0;
                        state_q    <= (kind_q == K_LOAD) ? S_WB : S_FETCH;
                    end else if (cnt_q == CNT_LAST) begin
                        memread_q  <= 1'b0;
                        memwrite_q <= 1'b0;
                        timeout_q  <= 1'b1;
                        state_q    <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Single-cycle strobes follow the state and the ready input of that cycle.
    // Fetch is gated by Reset_L so nothing is requested while reset is held.
    logic in_fetch, exec_branch, store_done, in_wb, retire;

    assign in_fetch    = (state_q == S_FETCH) && Reset_L;
    assign exec_branch = (state_q == S_EXEC) && (kind_q == K_CBZ || kind_q == K_B);
    assign store_done  = (state_q == S_MEM) && (kind_q == K_STORE) && bus.dmem_ready;
    assign in_wb       = (state_q == S_WB);
    assign retire      = exec_branch || store_done || in_wb;

    assign bus.imem_req      = in_fetch;
    assign bus.ir_write      = in_fetch && bus.imem_ready;
    assign bus.pc_write      = retire;
    assign bus.pc_src        = exec_branch && (uncond_q || (branch_q && bus.zero));
    assign bus.regwrite      = in_wb;
    assign bus.instr_done    = retire;
    assign bus.reg2loc       = reg2loc_q;
    assign bus.alusrc        = alusrc_q;
    assign bus.mem2reg       = mem2reg_q;
    assign bus.branch        = branch_q;
    assign bus.uncond_branch = uncond_q;
    assign bus.aluop         = aluop_q;
    assign bus.signop        = signop_q;
    assign bus.memread       = memread_q;
    assign bus.memwrite      = memwrite_q;
    assign bus.illegal       = illegal_q;
    assign bus.timeout       = timeout_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction reference built from the
// opcode pattern table predicts every cycle's state, strobes and registered controls.
module tb_multicycle_control;
    localparam int MEM_TIMEOUT = 16;
    localparam int K_LOAD = 1, K_STORE = 2, K_ALU = 3, K_CBZ = 4, K_B = 5;
    localparam int NEVER = 99;

    typedef struct packed {
        logic [2:0] kind;
        logic       r2l, asrc, m2r, br, ub;
        logic [3:0] aluop;
        logic [2:0] sop;
    } ctl_t;

    logic CLK;
    logic Reset_L;
    int   checks   = 0;
    int   errors   = 0;
    int   n_resets = 0;

    string pats [11];
    ctl_t  ctl_tbl [11];

    multicycle_control_if #(.ALUOP_W(4)) bus  ();
    multicycle_control_if #(.ALUOP_W(4)) bus2 ();

    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(MEM_TIMEOUT), .EN_MOVZ(1'b1)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .bus(bus)
    );

    // Second instance with MOVZ disabled, permanently fed a MOVZ opcode.
    multicycle_control #(.ALUOP_W(4), .MEM_TIMEOUT(MEM_TIMEOUT), .EN_MOVZ(1'b0)) dut_nomovz (
        .CLK(CLK), .Reset_L(Reset_L), .bus(bus2)
    );

    assign bus2.opcode     = 11'b11010010100;
    assign bus2.imem_ready = 1'b1;
    assign bus2.dmem_ready = 1'b0;
    assign bus2.zero       = 1'b0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {imem_req, ir_write, pc_write, pc_src, memread, memwrite, regwrite, instr_done, illegal, timeout}
    function automatic logic [9:0] obs();
        return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.memread,
                bus.memwrite, bus.regwrite, bus.instr_done, bus.illegal, bus.timeout};
    endfunction

    function automatic logic [11:0] obs_ctl();
        return {bus.reg2loc, bus.alusrc, bus.mem2reg, bus.branch, bus.uncond_branch,
                bus.aluop, bus.signop};
    endfunction

    function automatic ctl_t mk(input int k, input bit r2l, input bit asrc, input bit m2r,
                                input bit br, input bit ub, input logic [3:0] alu,
                                input logic [2:0] sop);
        ctl_t c;
        c.kind = 3'(k); c.r2l = r2l; c.asrc = asrc; c.m2r = m2r;
        c.br = br; c.ub = ub; c.aluop = alu; c.sop = sop;
        return c;
    endfunction

    function automatic bit pat_match(input string p, input logic [10:0] op);
        for (int i = 0; i < 11; i++) begin
            byte ch;
            ch = p[i];
            if (ch != "?" && ((ch == "1") != op[10-i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic decode_ref(input logic [10:0] op, output ctl_t c, output bit ok);
        ok = 1'b0;
        c  = '0;
        for (int r = 0; r < 11; r++)
            if (!ok && pat_match(pats[r], op)) begin
                c  = ctl_tbl[r];
                ok = 1'b1;
            end
    endtask

    function automatic logic [10:0] gen_op(input int row);
        logic [10:0] op;
        string       p;
        op = 11'($urandom);
        p  = pats[row];
        for (int i = 0; i < 11; i++)
            if (p[i] != "?") op[10-i] = (p[i] == "1");
        return op;
    endfunction

    // Called at a falling edge; leaves the DUT out of reset at the next falling edge.
    task automatic do_reset();
        if (n_resets > 0) begin
            #1;
            check("nomovz_state", 32'(bus2.state), 32'd7);
            check("nomovz_illegal_req", {bus2.illegal, bus2.imem_req}, 2'b10);
        end
        n_resets++;
        Reset_L = 1'b0;
        #1;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_out", 32'(obs()), 32'd0);
        check("rst_ctl", 32'(obs_ctl()), 32'd0);
        @(negedge CLK);
        Reset_L = 1'b1;
    endtask

    task automatic expect_halt(input string tag, input logic [1:0] flags);
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check({tag, "_state"}, 32'(bus.state), 32'd7);
            check({tag, "_out"}, 32'(obs()), {22'd0, 8'd0, flags});
            @(negedge CLK);
        end
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();
    endtask

    // One instruction: fl/ml = cycles of waiting before ready (NEVER = no ready),
    // rst_at = MEM cycle at which Reset_L is pulled, or -1.
    task automatic run_instr(input logic [10:0] op, input int fl, input int ml,
                             input bit z, input int rst_at);
        ctl_t c;
        bit   ok, is_br, is_ld, is_st, last, st_done;
        logic [11:0] exp_ctl;
        decode_ref(op, c, ok);
        exp_ctl = {c.r2l, c.asrc, c.m2r, c.br, c.ub, c.aluop, c.sop};

        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            bus.imem_ready = (i == fl);
            bus.dmem_ready = 1'b0;
            bus.opcode     = 11'($urandom);
            #1;
            check("fetch_state", 32'(bus.state), 32'd0);
            check("fetch_out", 32'(obs()), 32'({1'b1, (i == fl), 8'd0}));
            @(negedge CLK);
            if (i == fl) break;
        end
        if (fl >= MEM_TIMEOUT) begin
            expect_halt("fetch_tmo", 2'b01);
            return;
        end

        bus.imem_ready = 1'b0;
        bus.opcode     = op;
        #1;
        check("decode_state", 32'(bus.state), 32'd1);
        check("decode_out", 32'(obs()), 32'd0);
        @(negedge CLK);
        bus.opcode = 11'($urandom);
        if (!ok) begin
            expect_halt("illegal", 2'b10);
            return;
        end

        is_br = (c.kind == 3'(K_CBZ)) || (c.kind == 3'(K_B));
        is_ld = (c.kind == 3'(K_LOAD));
        is_st = (c.kind == 3'(K_STORE));
        bus.zero = z;
        #1;
        check("exec_state", 32'(bus.state), 32'd2);
        check("exec_ctl", 32'(obs_ctl()), 32'(exp_ctl));
        check("exec_out", 32'(obs()),
              32'({2'b00, is_br, is_br & (c.ub | (c.br & z)), 3'b000, is_br, 2'b00}));
        @(negedge CLK);
        if (is_br) return;

        if (is_ld || is_st) begin
            for (int i = 0; i < MEM_TIMEOUT; i++) begin
                bus.dmem_ready = (i == ml);
                last    = (i == ml);
                st_done = is_st & last;
                #1;
                check("mem_state", 32'(bus.state), 32'd3);
                check("mem_out", 32'(obs()),
                      32'({2'b00, st_done, 1'b0, is_ld, is_st, 1'b0, st_done, 2'b00}));
                if (i == rst_at) begin
                    do_reset();
                    bus.dmem_ready = 1'b0;
                    return;
                end
                @(negedge CLK);
                if (last) break;
            end
            bus.dmem_ready = 1'b0;
            if (ml >= MEM_TIMEOUT) begin
                expect_halt("mem_tmo", 2'b01);
                return;
            end
            if (is_st) return;
        end

        #1;
        check("wb_state", 32'(bus.state), 32'd4);
        check("wb_ctl", 32'(obs_ctl()), 32'(exp_ctl));
        check("wb_out", 32'(obs()), 32'({2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00}));
        @(negedge CLK);
    endtask

    initial begin
        Reset_L        = 1'b0;
        bus.opcode     = '0;
        bus.zero       = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;

        pats[0]  = "??111000010"; ctl_tbl[0]  = mk(K_LOAD,  0, 1, 1, 0, 0, 4'b0010, 3'b001);
        pats[1]  = "??111000000"; ctl_tbl[1]  = mk(K_STORE, 1, 1, 0, 0, 0, 4'b0010, 3'b001);
        pats[2]  = "110100101??"; ctl_tbl[2]  = mk(K_ALU,   0, 1, 0, 0, 0, 4'b1000, 3'b100);
        pats[3]  = "?0?01011???"; ctl_tbl[3]  = mk(K_ALU,   0, 0, 0, 0, 0, 4'b0010, 3'b000);
        pats[4]  = "?0?10001???"; ctl_tbl[4]  = mk(K_ALU,   0, 1, 0, 0, 0, 4'b0010, 3'b000);
        pats[5]  = "?1?01011???"; ctl_tbl[5]  = mk(K_ALU,   0, 0, 0, 0, 0, 4'b0110, 3'b000);
        pats[6]  = "?1?10001???"; ctl_tbl[6]  = mk(K_ALU,   0, 1, 0, 0, 0, 4'b0110, 3'b000);
        pats[7]  = "?0001010???"; ctl_tbl[7]  = mk(K_ALU,   0, 0, 0, 0, 0, 4'b0000, 3'b000);
        pats[8]  = "?0101010???"; ctl_tbl[8]  = mk(K_ALU,   0, 0, 0, 0, 0, 4'b0001, 3'b000);
        pats[9]  = "?011010????"; ctl_tbl[9]  = mk(K_CBZ,   1, 0, 0, 1, 0, 4'b0111, 3'b011);
        pats[10] = "?00101?????"; ctl_tbl[10] = mk(K_B,     0, 0, 0, 0, 1, 4'b0000, 3'b010);

        do_reset();

        run_instr(11'b10001011000, 0, 0, 1'b0, -1);          // ADDREG, ready tied high
        run_instr(11'b10001011000, 0, 0, 1'b0, -1);
        run_instr(11'b11111000010, 0, 2, 1'b0, -1);          // LDUR, 3 memread cycles
        run_instr(11'b10110100101, 1, 0, 1'b1, -1);          // CBZ taken
        run_instr(11'b10110100011, 0, 0, 1'b0, -1);          // CBZ not taken
        run_instr(11'b00010100000, 0, 0, 1'b0, -1);          // B
        run_instr(11'b11010010110, 0, 0, 1'b0, -1);          // MOVZ enabled
        run_instr(11'b11111000000, 0, MEM_TIMEOUT - 1, 1'b0, -1); // ready on last allowed cycle
        run_instr(11'b11111000000, MEM_TIMEOUT - 1, 0, 1'b0, -1);
        run_instr(11'b11111000000, 0, NEVER, 1'b0, -1);      // STUR timeout
        run_instr(11'b10001011000, NEVER, 0, 1'b0, -1);      // fetch timeout
        run_instr(11'b00000000000, 0, 0, 1'b0, -1);          // illegal
        run_instr(11'b11111000000, 0, 5, 1'b0, 2);           // reset mid-MEM
        run_instr(11'b10001011000, 0, 0, 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            int          r, fl, ml;
            logic [10:0] op;
            r  = $urandom_range(0, 11);
            op = (r == 11) ? 11'($urandom) : gen_op(r);
            fl = ($urandom_range(0, 49) == 0) ? NEVER :
                 ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 3);
            ml = ($urandom_range(0, 29) == 0) ? NEVER :
                 ($urandom_range(0, 7) == 0) ? MEM_TIMEOUT - 1 : $urandom_range(0, 4);
            run_instr(op, fl, ml, 1'($urandom),
                      ($urandom_range(0, 39) == 0) ? 0 : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
